grom_io: RTL and testbench
==========================

Name: grom_io

Overview:
- Memory-mapped I/O responder for the grom CPU bus.
- Decodes I/O cycles (ioreq=1) issued by IN/OUT instructions and returns read data within the CPU's two-cycle sample window.
- Provides an 8-bit LED output port, a UART transmitter with a small TX FIFO, a status register and a programmable baud divider.
- Sits beside RAM on the shared addr/data bus; RAM ignores cycles with ioreq=1.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..8.
BAUD_RESET, 8'd103, reset value of the BAUD register; bit period = BAUD+1 clocks.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
addr  in  12  CPU address; I/O register selected by addr[1:0]; decoded only when addr[11:2]==0.
data_in  in  8  write data from CPU data_out.
data_out  out  8  read data to CPU data_in.
we  in  1  write enable from CPU.
ioreq  in  1  I/O cycle qualifier from CPU.
leds  out  8  LED port register.
tx  out  1  UART serial output, idle high.

Behaviour:
- Reset (asynchronous, active-high):
  - data_out=0x00, leds=0x00, tx=1, BAUD=BAUD_RESET.
  - FIFO empty, overflow=0, TX FSM in IDLE.
  - Reset mid-frame aborts the frame; tx goes high immediately.
- Register map (addr[1:0]):
  - 0 LED: RW.
  - 1 UART_DATA: write pushes to FIFO; reads 0x00.
  - 2 STATUS: read {count[3:0], overflow, empty, full, busy}; a write with data bit3=1 clears overflow.
  - 3 BAUD: RW.
- Read path:
  - Every clock, data_out <= selected register if ioreq & !we & decode hit, else 0x00.
  - Latency: 1 clock. The CPU samples 2 clocks after presenting addr.
- Write path:
  - A write is qualified as ioreq & we & decode hit.
  - Action is taken only on the first cycle of a qualified write (rising-edge detect on the qualified strobe, registered previous value). A strobe held for several cycles therefore causes exactly one push or update.
  - Edge-detect state resets to 0.
- FIFO:
  - Circular buffer with wrapping read/write pointers and count 0..FIFO_DEPTH.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - Push when full: data is dropped, overflow is set (sticky), count unchanged.
  - Push and pop in the same cycle: fullness is evaluated before the pop. If full, the push is dropped and overflow is set. Otherwise both happen and count is unchanged.
- TX FSM (states IDLE, START, DATA, STOP; bit counter, baud counter):
  - IDLE: tx=1. If FIFO not empty, pop into the shift register, load baud counter=BAUD, go to START.
  - START: tx=0 for BAUD+1 clocks, then DATA.
  - DATA: 8 bits, LSB first, BAUD+1 clocks each, then STOP.
  - STOP: tx=1 for BAUD+1 clocks, then IDLE. A queued byte starts on the next clock, so there is no extra idle bit.
  - busy = (state != IDLE).
  - A BAUD write mid-frame takes effect at the next bit boundary, when the counter is reloaded.
  - BAUD=0 is legal: 1 clock per bit.
- Undecoded addresses (addr[11:2]!=0): reads return 0x00; writes are ignored.

Optional Feature:
- Macro: GROM_IO_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent after DATA, lasting BAUD+1 clocks, in an extra PARITY state before STOP. Frame is 11 bits. STATUS bit4 of the count field is unchanged.
- Undefined: 8N1, 10-bit frame, no PARITY state.

Test Plan:
- Reset, then IN from 0x002 -> data_out=0x04 (empty=1, count=0); leds=0x00; tx=1; IN from 0x003 -> 0x67.
- OUT 0x000 with 0xA5, hold we&ioreq 3 cycles -> leds=0xA5 after 1 clock, single update; IN from 0x000 -> 0xA5 two clocks after addr.
- BAUD=3, OUT 0x001 with 0x55 -> tx low 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks (40 clocks total); busy=1 throughout; with GROM_IO_PARITY_EN, parity bit=0 and 44 clocks total.
- BAUD=3, push 10 bytes back-to-back (first pops immediately) -> first 9 accepted, 10th dropped, STATUS reads overflow=1, full=1; write 0x08 to 0x002 -> overflow=0; all 9 bytes transmitted back-to-back with no idle gap.
- Assert reset mid-DATA of a frame with FIFO count=3 -> tx=1 asynchronously, STATUS=0x04 after release, no further tx activity.
- Writes/reads at 0x104 and 0x004 -> no register change, data_out=0x00.

Source files
------------

// File: rtl/grom_io.sv
// grom CPU I/O responder: LED port, UART TX with FIFO, STATUS and BAUD registers.
// Optional `GROM_IO_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module grom_io #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] BAUD_RESET = 8'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        we,
  input  logic        ioreq,
  output logic [7:0]  leds,
  output logic        tx,
  output logic [2:0]  o_dbg_state
);

  localparam int         PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH4 = 4'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef GROM_IO_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } tx_state_t;

  logic [7:0]    r_leds;
  logic [7:0]    r_baud;
  logic [7:0]    r_data_out;
  logic          r_wr_prev;
  logic [7:0]    r_fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [3:0]    r_count;
  logic          r_overflow;
  tx_state_t     r_state;
  logic [7:0]    r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
`ifdef GROM_IO_PARITY_EN
  logic          r_parity;
`endif

  tx_state_t     w_state_nxt;
  logic [7:0]    w_baud_cnt_nxt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_pop;
  logic          w_tx;
  logic [7:0]    w_rd_sel;

  logic w_hit, w_wr, w_wr_pulse, w_rd, w_full, w_empty, w_busy, w_push, w_push_ok, w_bit_end;

  assign w_hit      = (addr[11:2] == 10'd0);
  assign w_wr       = ioreq & we & w_hit;
  assign w_wr_pulse = w_wr & ~r_wr_prev;
  assign w_rd       = ioreq & ~we & w_hit;
  assign w_full     = (r_count == DEPTH4);
  assign w_empty    = (r_count == 4'd0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push     = w_wr_pulse & (addr[1:0] == 2'd1);
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO always drops.
  assign w_push_ok  = w_push & ~w_full;
  assign w_bit_end  = (r_baud_cnt == 8'd0);

  always_comb begin
    w_rd_sel = 8'h00;
    case (addr[1:0])
      2'd0:    w_rd_sel = r_leds;
      2'd1:    w_rd_sel = 8'h00;
      2'd2:    w_rd_sel = {r_count, r_overflow, w_empty, w_full, w_busy};
      default: w_rd_sel = r_baud;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= 8'h00;
      r_wr_prev  <= 1'b0;
      r_leds     <= 8'h00;
      r_baud     <= BAUD_RESET;
      r_overflow <= 1'b0;
    end else begin
      r_data_out <= w_rd ? w_rd_sel : 8'h00;
      r_wr_prev  <= w_wr;
      if (w_wr_pulse && addr[1:0] == 2'd0) r_leds <= data_in;
      if (w_wr_pulse && addr[1:0] == 2'd3) r_baud <= data_in;
      if (w_push && w_full) r_overflow <= 1'b1;
      else if (w_wr_pulse && addr[1:0] == 2'd2 && data_in[3]) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 4'd0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

`ifdef GROM_IO_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^r_fifo_mem[r_rptr];
  end
`endif

  // The baud counter reloads from r_baud at every bit boundary, so BAUD writes land there.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_pop          = 1'b0;
    w_tx           = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shift_nxt    = r_fifo_mem[r_rptr];
          w_baud_cnt_nxt = r_baud;
          w_state_nxt    = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_baud_cnt_nxt = r_baud;
          w_bit_cnt_nxt  = 3'd0;
          w_state_nxt    = S_DATA;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt - 8'd1;
        end
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end) begin
          w_baud_cnt_nxt = r_baud;
          if (r_bit_cnt == 3'd7) begin
`ifdef GROM_IO_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt - 8'd1;
        end
      end
`ifdef GROM_IO_PARITY_EN
      S_PARITY: begin
        w_tx = r_parity;
        if (w_bit_end) begin
          w_baud_cnt_nxt = r_baud;
          w_state_nxt    = S_STOP;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt - 8'd1;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          // A queued byte starts straight after the stop bit, leaving no idle gap.
          if (!w_empty) begin
            w_pop          = 1'b1;
            w_shift_nxt    = r_fifo_mem[r_rptr];
            w_baud_cnt_nxt = r_baud;
            w_state_nxt    = S_START;
          end else begin
            w_state_nxt    = S_IDLE;
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign data_out    = r_data_out;
  assign leds        = r_leds;
  assign tx          = w_tx;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_grom_io.sv
// Bench for grom_io: bus driver tasks, randomized data, and a reference model that
// builds the expected serial waveform from the byte list and the baud value.
module tb_grom_io;

  localparam int DEPTH = 8;
`ifdef GROM_IO_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        we;
  logic        ioreq;
  logic [7:0]  leds;
  logic        tx;
  logic [2:0]  dbg_state;

  grom_io #(.FIFO_DEPTH(DEPTH), .BAUD_RESET(8'd103)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .data_out(data_out),
    .we(we), .ioreq(ioreq), .leds(leds), .tx(tx), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic       tx_log[$];
  bit         log_en = 1'b0;

  always @(negedge clk) if (log_en) tx_log.push_back(tx);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; we = 1'b1; ioreq = 1'b1;
    @(negedge clk);
    we = 1'b0; ioreq = 1'b0;
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; we = 1'b0; ioreq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    d = data_out;
    ioreq = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(a, d);
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  task automatic start_log();
    tx_log.delete();
    log_en = 1'b1;
  endtask

  // reference model: concatenated frames of exp_q, then idle-high forever
  task automatic check_wave(input string tag, input int baud);
    logic wave[$];
    int   s, mism, extra;
    wave = {};
    foreach (exp_q[k]) begin
      for (int c = 0; c <= baud; c++) wave.push_back(1'b0);
      for (int b = 0; b < 8; b++)
        for (int c = 0; c <= baud; c++) wave.push_back(exp_q[k][b]);
`ifdef GROM_IO_PARITY_EN
      for (int c = 0; c <= baud; c++) wave.push_back(^exp_q[k]);
`endif
      for (int c = 0; c <= baud; c++) wave.push_back(1'b1);
    end
    s = -1;
    for (int i = 0; i < tx_log.size(); i++)
      if (tx_log[i] === 1'b0) begin s = i; break; end
    check({tag, "_start_seen"}, {15'd0, s >= 0}, 16'd1);
    mism = 0;
    extra = 0;
    if (s >= 0) begin
      for (int i = 0; i < wave.size(); i++) begin
        if (s + i >= tx_log.size()) mism++;
        else if (tx_log[s + i] !== wave[i]) mism++;
      end
      for (int i = s + wave.size(); i < tx_log.size(); i++)
        if (tx_log[i] !== 1'b1) extra++;
    end
    check({tag, "_wave"}, 16'(mism), 16'd0);
    check({tag, "_tail_idle"}, 16'(extra), 16'd0);
    log_en = 1'b0;
  endtask

  logic [7:0]  m_leds;
  logic [7:0]  m_baud;
  logic [7:0]  v;
  logic [11:0] a;
  logic [9:0]  hi;
  logic [7:0]  m_fifo[$];
  bit          m_inflight;
  bit          m_ovf;
  int          nbytes;
  int          zeros;

  initial begin
    reset = 1'b1; addr = '0; data_in = '0; we = 1'b0; ioreq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", {8'h00, data_out}, 16'h0000);
    check("rst_leds", {8'h00, leds}, 16'h0000);
    check("rst_tx", {15'd0, tx}, 16'd1);
    reset = 1'b0;
    m_leds = 8'h00;
    m_baud = 8'h67;

    read_check("status_reset", 12'h002, 8'h04);
    read_check("baud_reset", 12'h003, 8'h67);
    read_check("uart_data_read", 12'h001, 8'h00);

    // LED write held three cycles with data changing: only the first cycle counts
    @(negedge clk);
    addr = 12'h000; data_in = 8'hA5; we = 1'b1; ioreq = 1'b1;
    @(posedge clk); #1;
    check("led_after_1clk", {8'h00, leds}, 16'h00A5);
    @(negedge clk); data_in = 8'h3C;
    @(negedge clk);
    @(negedge clk); we = 1'b0; ioreq = 1'b0;
    check("led_single_update", {8'h00, leds}, 16'h00A5);
    m_leds = 8'hA5;
    read_check("led_read", 12'h000, m_leds);

    repeat (4) begin
      v = 8'($urandom);
      cpu_write(12'h000, v);
      m_leds = v;
      read_check("led_rand", 12'h000, m_leds);
    end

    // undecoded addresses alias onto each register's low bits but must be ignored
    cpu_write(12'h104, 8'h11);
    cpu_write(12'h004, 8'h22);
    cpu_write(12'h005, 8'h33);
    cpu_write(12'h007, 8'h44);
    read_check("undec_rd_104", 12'h104, 8'h00);
    read_check("undec_rd_004", 12'h004, 8'h00);
    repeat (3) begin
      hi = 10'($urandom_range(1, 1023));
      a  = {hi, 2'($urandom)};
      cpu_write(a, 8'($urandom));
      read_check("undec_rd_rand", a, 8'h00);
    end
    read_check("undec_led_kept", 12'h000, m_leds);
    read_check("undec_baud_kept", 12'h003, m_baud);
    read_check("undec_status_kept", 12'h002, 8'h04);

    // single 0x55 frame at BAUD=3, UART write held three cycles
    cpu_write(12'h003, 8'h03);
    m_baud = 8'h03;
    read_check("baud_rw", 12'h003, m_baud);
    start_log();
    @(negedge clk);
    addr = 12'h001; data_in = 8'h55; we = 1'b1; ioreq = 1'b1;
    repeat (3) @(negedge clk);
    we = 1'b0; ioreq = 1'b0;
    repeat (5) @(negedge clk);
    read_check("status_busy", 12'h002, 8'h05);
    repeat (FRAME_BITS * 4 + 30) @(negedge clk);
    exp_q = {8'h55};
    check_wave("frame_55", 3);
    read_check("status_after_frame", 12'h002, 8'h04);

    // randomized short bursts at small baud values, including BAUD=0
    for (int b = 0; b < 3; b++) begin
      cpu_write(12'h003, 8'(b));
      m_baud = 8'(b);
      nbytes = $urandom_range(1, 3);
      exp_q = {};
      start_log();
      for (int k = 0; k < nbytes; k++) begin
        v = 8'($urandom);
        exp_q.push_back(v);
        cpu_write(12'h001, v);
      end
      repeat (nbytes * FRAME_BITS * (b + 1) + 30) @(negedge clk);
      check_wave("frame_rand", b);
    end

    // overflow: ten pushes while the first byte is still being sent
    cpu_write(12'h003, 8'h03);
    m_baud = 8'h03;
    m_fifo = {};
    exp_q = {};
    m_inflight = 1'b0;
    m_ovf = 1'b0;
    start_log();
    repeat (10) begin
      v = 8'($urandom);
      cpu_write(12'h001, v);
      if (!m_inflight) begin
        m_inflight = 1'b1;
        exp_q.push_back(v);
      end else if (m_fifo.size() < DEPTH) begin
        m_fifo.push_back(v);
        exp_q.push_back(v);
      end else begin
        m_ovf = 1'b1;
      end
    end
    read_check("status_overflow", 12'h002,
               {4'(m_fifo.size()), m_ovf, m_fifo.size() == 0, m_fifo.size() == DEPTH, 1'b1});
    cpu_write(12'h002, 8'h08);
    m_ovf = 1'b0;
    read_check("status_ovf_clr", 12'h002,
               {4'(m_fifo.size()), m_ovf, m_fifo.size() == 0, m_fifo.size() == DEPTH, 1'b1});
    repeat (exp_q.size() * FRAME_BITS * 4 + 40) @(negedge clk);
    check_wave("burst9", 3);
    read_check("status_drained", 12'h002, 8'h04);

    // asynchronous reset in the middle of a frame with three bytes queued
    repeat (4) cpu_write(12'h001, 8'($urandom));
    repeat (6) @(negedge clk);
    read_check("status_pre_reset", 12'h002, 8'h31);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", {15'd0, tx}, 16'd1);
    check("async_rst_leds", {8'h00, leds}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    read_check("status_post_reset", 12'h002, 8'h04);
    read_check("baud_post_reset", 12'h003, 8'h67);
    start_log();
    repeat (200) @(negedge clk);
    log_en = 1'b0;
    zeros = 0;
    foreach (tx_log[i]) if (tx_log[i] !== 1'b1) zeros++;
    check("no_tx_after_reset", 16'(zeros), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
